// File: rtl/cache_line_ram_pkg.sv
// Shared types and defaults for the cache line store: geometry and flush FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_line_ram_pkg;

    localparam int CACHE_IDX_W  = 4;
    localparam int CACHE_LINE_W = 64;

    typedef enum logic [1:0] {
        CRAM_IDLE  = 2'd0,
        CRAM_FLUSH = 2'd1,
        CRAM_DONE  = 2'd2
    } cram_state_e;

    // Byte-strobe count for a line of the given bit width.
    function automatic int line_nb(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/cache_line_ram_if.sv
// Request/response bundle between a cache controller (master) and one way's line store (slave).
// Latency: n/a (wiring only).
// Backpressure: master may only issue rreq/wen/flush_req while ready is high.
interface cache_line_ram_if
    import cache_line_ram_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int WIDTH = CACHE_LINE_W
) ();
    localparam int NB = line_nb(WIDTH);

    logic             ready;
    logic             rreq;
    logic [IDX_W-1:0] rindex;
    logic             rvalid;
    logic             rhit;
    logic [WIDTH-1:0] rdata;
    logic             wen;
    logic [IDX_W-1:0] windex;
    logic [NB-1:0]    wstrb;
    logic [WIDTH-1:0] wdata;
    logic             flush_req;
    logic             flush_done;

    modport master (
        input  ready, rvalid, rhit, rdata, flush_done,
        output rreq, rindex, wen, windex, wstrb, wdata, flush_req
    );

    modport slave (
        output ready, rvalid, rhit, rdata, flush_done,
        input  rreq, rindex, wen, windex, wstrb, wdata, flush_req
    );
endinterface

// File: rtl/cache_byte_merge.sv
// Byte-granular merge: strobed bytes from new_line, the rest from old_line.
// Latency: combinational.
// Backpressure: none.
module cache_byte_merge #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]   old_line,
    input  logic [WIDTH-1:0]   new_line,
    input  logic [WIDTH/8-1:0] strb,
    output logic [WIDTH-1:0]   merged
);
    always_comb begin
        merged = old_line;
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_line[8*i +: 8];
        end
    end
endmodule

// File: rtl/cache_line_ram.sv
// One cache way's data/valid store: byte-strobed writes, registered read, flush sequencer.
// Latency: read 1 cycle; flush DEPTH+1 cycles of ready=0. CACHE_RAM_BYPASS_EN forwards same-index writes to reads.
// Backpressure: ready low during FLUSH/DONE; requests presented then are dropped, owner must retry.
module cache_line_ram
    import cache_line_ram_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int WIDTH = CACHE_LINE_W
) (
    input logic             clk,
    input logic             rstn,
    cache_line_ram_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;

    cram_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             rvalid_q, rvalid_d;
    logic             rhit_q, rhit_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             ready;
    logic             rd_acc;
    logic             wr_acc;
    logic             fl_acc;
    logic [WIDTH-1:0] wr_line;

    assign ready  = (state_q == CRAM_IDLE);
    assign rd_acc = ready & bus.rreq;
    assign wr_acc = ready & bus.wen;
    assign fl_acc = ready & bus.flush_req;

    // Shared by the write path and the same-index read bypass.
    cache_byte_merge #(.WIDTH(WIDTH)) u_merge (
        .old_line (mem_q[bus.windex]),
        .new_line (bus.wdata),
        .strb     (bus.wstrb),
        .merged   (wr_line)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (wr_acc) valid_d[bus.windex] = 1'b1;
        unique case (state_q)
            CRAM_IDLE: begin
                if (fl_acc) begin
                    state_d = CRAM_FLUSH;
                    cnt_d   = '0;
                end
            end
            CRAM_FLUSH: begin
                valid_d[cnt_q] = 1'b0;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = CRAM_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CRAM_DONE: state_d = CRAM_IDLE;
            default:   state_d = CRAM_IDLE;
        endcase
    end

    // Array is sampled before this edge's write, so reads are read-before-write unless bypassed.
    always_comb begin
        rvalid_d = rd_acc;
        rhit_d   = rhit_q;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            rdata_d = mem_q[bus.rindex];
            rhit_d  = valid_q[bus.rindex];
`ifdef CACHE_RAM_BYPASS_EN
            if (wr_acc && (bus.windex == bus.rindex)) begin
                rdata_d = wr_line;
                rhit_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= CRAM_IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            rvalid_q <= 1'b0;
            rhit_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            rvalid_q <= rvalid_d;
            rhit_q   <= rhit_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[bus.windex] <= wr_line;
    end

    assign bus.ready      = ready;
    assign bus.rvalid     = rvalid_q;
    assign bus.rhit       = rhit_q;
    assign bus.rdata      = rdata_q;
    assign bus.flush_done = (state_q == CRAM_DONE);
endmodule
